// File: rtl/semaforo_pkg.sv
// Shared types for the pedestrian-crossing controller: FSM states, lamp bundle,
// the state/blink-to-lamp decode, and the elaboration-time timing check.
package semaforo_pkg;

    typedef enum logic [2:0] {
        VEH_GREEN  = 3'd0,
        VEH_YELLOW = 3'd1,
        ALL_RED    = 3'd2,
        PED_WALK   = 3'd3,
        PED_FLASH  = 3'd4,
        NIGHT      = 3'd5
    } state_t;

    typedef struct packed {
        logic veic_vm;
        logic veic_am;
        logic veic_vd;
        logic ped_vm;
        logic ped_vd;
    } lamp_t;

    function automatic lamp_t decode_lamps(input state_t st, input logic blink);
        lamp_t l;
        l = '0;
        case (st)
            VEH_GREEN:  begin l.veic_vd = 1'b1; l.ped_vm = 1'b1; end
            VEH_YELLOW: begin l.veic_am = 1'b1; l.ped_vm = 1'b1; end
            ALL_RED:    begin l.veic_vm = 1'b1; l.ped_vm = 1'b1; end
            PED_WALK:   begin l.veic_vm = 1'b1; l.ped_vd = 1'b1; end
            PED_FLASH:  begin l.veic_vm = 1'b1; l.ped_vd = blink; end
            NIGHT:      l.veic_am = blink;
            // unreachable encodings fall back to the safe all-red picture
            default:    begin l.veic_vm = 1'b1; l.ped_vm = 1'b1; end
        endcase
        return l;
    endfunction

    function automatic bit timing_ok(input int unsigned t, input int unsigned w);
        return (t != 0) && (t < (32'd1 << w));
    endfunction

endpackage

// File: rtl/semaforo_temporizador.sv
// Phase timer: counts up from 0 after clear and saturates at limit_i.
// expire_o is combinational from the count, so it is valid in the same cycle.
module semaforo_temporizador #(
    parameter int unsigned W_CNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [W_CNT-1:0] limit_i,
    output logic [W_CNT-1:0] count_o,
    output logic             expire_o
);

    logic [W_CNT-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_q < limit_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o  = count_q;
    assign expire_o = (count_q == limit_i);

endmodule

// File: rtl/semaforo_pedestre_cfg.sv
// Pedestrian-crossing light controller with latched requests and night blink mode.
// Lamps are a Moore decode of registered state/blink; requests show one cycle after the press.
module semaforo_pedestre_cfg
    import semaforo_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN = 6,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_ALL_RED   = 1,
    parameter int unsigned T_WALK      = 4,
    parameter int unsigned T_FLASH     = 4,
    parameter int unsigned FLASH_HALF  = 1,
    parameter int unsigned W_CNT       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic botao_pedestre,
    input  logic modo_noturno,
    output logic veic_vermelho,
    output logic veic_amarelo,
    output logic veic_verde,
    output logic ped_vermelho,
    output logic ped_verde,
    output logic pedido_pendente
);

    generate
        if (!(timing_ok(T_MIN_GREEN, W_CNT) && timing_ok(T_YELLOW, W_CNT) &&
              timing_ok(T_ALL_RED, W_CNT) && timing_ok(T_WALK, W_CNT) &&
              timing_ok(T_FLASH, W_CNT) && timing_ok(FLASH_HALF, W_CNT))) begin : g_bad_timing
            $error("semaforo_pedestre_cfg: timing parameter is 0 or does not fit in W_CNT bits");
        end
    endgenerate

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             blink_q, blink_d;
    logic [W_CNT-1:0] cnt;
    logic [W_CNT-1:0] limit;
    logic             expire;
    logic             entering;
    logic             tmr_clear;
    logic             flash_tick;
    lamp_t            lamps;

    semaforo_temporizador #(.W_CNT(W_CNT)) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (tmr_clear),
        .limit_i  (limit),
        .count_o  (cnt),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= VEH_GREEN;
            req_q   <= 1'b0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            blink_q <= blink_d;
        end
    end

    assign flash_tick = ((32'(cnt) % FLASH_HALF) == (FLASH_HALF - 32'd1));

    always_comb begin
        state_d = state_q;
        limit   = W_CNT'(FLASH_HALF - 1);
        case (state_q)
            VEH_GREEN: begin
                // Saturating at the minimum green lets a late press leave on the next edge.
                limit = W_CNT'(T_MIN_GREEN - 1);
                if (modo_noturno) begin
                    state_d = NIGHT;
                end else if ((req_q || botao_pedestre) && expire) begin
                    state_d = VEH_YELLOW;
                end
            end
            VEH_YELLOW: begin
                limit = W_CNT'(T_YELLOW - 1);
                if (expire) state_d = ALL_RED;
            end
            ALL_RED: begin
                limit = W_CNT'(T_ALL_RED - 1);
                if (expire) state_d = PED_WALK;
            end
            PED_WALK: begin
                limit = W_CNT'(T_WALK - 1);
                if (expire) state_d = PED_FLASH;
            end
            PED_FLASH: begin
                limit = W_CNT'(T_FLASH - 1);
                if (expire) state_d = VEH_GREEN;
            end
            NIGHT: begin
                if (!modo_noturno) state_d = VEH_GREEN;
            end
            default: state_d = VEH_GREEN;
        endcase

        entering  = (state_d != state_q);
        // In NIGHT the timer wraps every half-period and drives the blink directly.
        tmr_clear = entering || ((state_q == NIGHT) && expire);

        req_d = req_q;
        if (entering && ((state_d == PED_WALK) || (state_d == NIGHT))) begin
            req_d = 1'b0;
        end else if (botao_pedestre &&
                     (state_q inside {VEH_GREEN, VEH_YELLOW, ALL_RED, PED_FLASH})) begin
            req_d = 1'b1;
        end

        blink_d = blink_q;
        if (entering) begin
            if ((state_d == PED_FLASH) || (state_d == NIGHT)) blink_d = 1'b1;
        end else if ((state_q == PED_FLASH) && flash_tick) begin
            blink_d = ~blink_q;
        end else if ((state_q == NIGHT) && expire) begin
            blink_d = ~blink_q;
        end
    end

    always_comb begin
        lamps = decode_lamps(state_q, blink_q);
    end

    assign veic_vermelho   = lamps.veic_vm;
    assign veic_amarelo    = lamps.veic_am;
    assign veic_verde      = lamps.veic_vd;
    assign ped_vermelho    = lamps.ped_vm;
    assign ped_verde       = lamps.ped_vd;
    assign pedido_pendente = req_q;

    a_no_conflict: assert property (@(posedge clk) disable iff (reset)
        !((veic_verde || veic_amarelo) && ped_verde));
    a_one_veh_lamp: assert property (@(posedge clk) disable iff (reset)
        $onehot0({veic_vermelho, veic_amarelo, veic_verde}));

endmodule

// File: tb/tb_semaforo_pedestre_cfg.sv
// Scoreboard bench: per-cycle expected lamp pictures are queued by the stimulus
// and checked mid-cycle by an independent monitor.
module tb_semaforo_pedestre_cfg;

    logic clk            = 1'b0;
    logic reset          = 1'b1;
    logic botao_pedestre = 1'b0;
    logic modo_noturno   = 1'b0;
    logic veic_vermelho, veic_amarelo, veic_verde;
    logic ped_vermelho, ped_verde, pedido_pendente;

    typedef struct {
        logic [5:0] vec;
        int         tst;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_test = 0;

    localparam logic [5:0] RESET_VEC = 6'b001100;

    always #5 clk = ~clk;

    semaforo_pedestre_cfg dut (
        .clk             (clk),
        .reset           (reset),
        .botao_pedestre  (botao_pedestre),
        .modo_noturno    (modo_noturno),
        .veic_vermelho   (veic_vermelho),
        .veic_amarelo    (veic_amarelo),
        .veic_verde      (veic_verde),
        .ped_vermelho    (ped_vermelho),
        .ped_verde       (ped_verde),
        .pedido_pendente (pedido_pendente)
    );

    // {veic_vm, veic_am, veic_vd, ped_vm, ped_vd, pedido}
    function automatic logic [5:0] vec_of(input byte c, input byte p);
        logic [4:0] l;
        case (c)
            "G":     l = 5'b00110;
            "Y":     l = 5'b01010;
            "R":     l = 5'b10010;
            "W":     l = 5'b10001;
            "f":     l = 5'b10001;
            "o":     l = 5'b10000;
            "N":     l = 5'b01000;
            default: l = 5'b00000;
        endcase
        return {l, (p == "1")};
    endfunction

    function automatic string rep(input string c, input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, c};
        return s;
    endfunction

    task automatic push(input logic [5:0] v, input int cyc);
        exp_t e;
        e.vec = v;
        e.tst = cur_test;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        botao_pedestre = 1'b0;
        modo_noturno   = 1'b0;
        push(RESET_VEC, -1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Cycle n: inputs held from edge n-1 until edge n; expected picture is the one before edge n.
    task automatic run(input string lamp, input string pend, input string btn, input string ngt);
        for (int n = 0; n < lamp.len(); n++) begin
            botao_pedestre = (btn[n] == "b");
            modo_noturno   = (ngt[n] == "1");
            push(vec_of(lamp[n], pend[n]), n);
            @(posedge clk);
            #1;
        end
        botao_pedestre = 1'b0;
        modo_noturno   = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({veic_vermelho, veic_amarelo, veic_verde, ped_vermelho, ped_verde,
                     pedido_pendente} !== e.vec) begin
                    n_err++;
                    $display("FAIL T%0d cyc%0d lamps {vm,am,vd,pvm,pvd,pend} got %b expected %b",
                             e.tst, e.cyc,
                             {veic_vermelho, veic_amarelo, veic_verde, ped_vermelho, ped_verde,
                              pedido_pendente}, e.vec);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        cur_test = 1;
        apply_reset();
        run(rep("G", 30), rep("0", 30), rep(".", 30), rep(".", 30));

        cur_test = 2;
        apply_reset();
        run("GGGGGGYYRWWWWfofoGGG",
            "00011111100000000000",
            "..b.......b.........",
            ".......1............");

        cur_test = 3;
        apply_reset();
        run({rep("G", 21), "YYRW"}, {rep("0", 21), "1110"},
            {rep(".", 20), "b", "...."}, rep(".", 25));

        cur_test = 4;
        apply_reset();
        run({"GGGGGGYYRWWWWfofo", rep("G", 6), "YYRW"},
            {"000111111000000", rep("1", 11), "0"},
            {"..b...........", "b", rep(".", 12)},
            rep(".", 27));

        cur_test = 5;
        apply_reset();
        run("GGGGNnNnNnGG", rep("0", 12), "...b........", "...111111...");

        cur_test = 6;
        apply_reset();
        run("GGGGGGYYRWW", "00011111100", "..b........", rep(".", 11));
        #1;
        push(RESET_VEC, -2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run("GGG", "000", "...", "...");

        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d expected entries unchecked (required 0)",
                     sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
